mem_dump_reader: RTL and testbench

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

---
 rtl/mem_dump_pkg.sv | 15 +
 rtl/mem_dump_reader.sv | 86 ++++++++
 tb/tb_mem_dump_reader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the memory dump reader.
package mem_dump_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Reads a block of words from a synchronous data memory and streams them
// downstream one at a time over a valid/ready handshake.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   ONE_CNT  = 1;
  localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              reissue;

  // A pause in CAP means the memory's one-cycle data window has passed, so the
  // read is redone when enable returns instead of capturing whatever is there.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      reissue   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= count;
            state     <= (count == '0) ? FIN : REQ;
          end
        end
        REQ: state <= CAP;
        CAP: begin
          if (reissue) begin
            reissue <= 1'b0;
            state   <= REQ;
          end else begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - ONE_CNT;
            addr      <= addr + ONE_ADDR;
            state     <= (remaining > ONE_CNT) ? REQ : FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end else if (state == CAP) begin
      reissue <= 1'b1;
    end
  end

  assign mem_re   = (state == REQ) && enable;
  assign done     = (state == FIN) && enable;
  assign mem_addr = addr;
  assign busy     = (state != IDLE);
  assign out_last = out_valid && (remaining == ONE_CNT);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: directed vector table, corner
// sequences and randomized dumps checked against an address-arithmetic model.
module tb_mem_dump_reader;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [256];

  mem_dump_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Read data is only meaningful the cycle after a strobe; otherwise it is junk.
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 16'($urandom);
  end

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  cnt;
    int          rmode;
    int          emode;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] c);
    start     = 1'b1;
    base_addr = b;
    count     = c;
    enable    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mem_re"},    32'(mem_re),    0);
    checkOutput({tag, "_mem_addr"},  32'(mem_addr),  0);
    checkOutput({tag, "_out_data"},  32'(out_data),  0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_out_last"},  32'(out_last),  0);
    checkOutput({tag, "_busy"},      32'(busy),      0);
    checkOutput({tag, "_done"},      32'(done),      0);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 five-cycle stall on word 2.
  // emode: 0 enable always, 1 random enable, 2 four-cycle pause in CAP of word 2.
  task automatic runDump(input logic [7:0] b, input logic [8:0] c, input int rmode, input int emode,
                         output logic [15:0] firstW, output logic [15:0] lastW);
    int words, mreCnt, cyc, hsCyc, doneCyc, firstValidCyc, stall, enOffLeft, busyCyc, budget;
    bit didDisable, prevHold;
    logic [15:0] prevData, expW;
    words = 0; mreCnt = 0; cyc = 0; hsCyc = -1; doneCyc = -1; firstValidCyc = -1;
    stall = 0; enOffLeft = 0; busyCyc = 0; didDisable = 0; prevHold = 0; prevData = '0;
    budget = 40 * (int'(c) + 1) + 20;
    firstW = '0;
    lastW  = '0;
    applyStimulus(b, c);
    while (cyc < budget && doneCyc < 0) begin
      enable = 1'b1;
      if (emode == 1) enable = ($urandom_range(0, 3) != 0);
      if (enOffLeft > 0) begin
        enable = 1'b0;
        enOffLeft--;
      end
      out_ready = 1'b1;
      if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2 && words == 1 && out_valid && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end
      start     = 1'($urandom_range(0, 1));
      base_addr = 8'($urandom);
      count     = 9'($urandom);
      @(negedge clock);
      if (busy) busyCyc++;
      if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
      if (prevHold) begin
        checkOutput("hold_valid", 32'(out_valid), 1);
        checkOutput("hold_data", 32'(out_data), 32'(prevData));
      end
      if (mem_re) begin
        mreCnt++;
        checkOutput("mem_addr", 32'(mem_addr), 32'((int'(b) + words) % 256));
        checkOutput("mem_re_while_enabled", 32'(enable), 1);
        if (emode == 2 && words == 1 && !didDisable) begin
          enOffLeft  = 4;
          didDisable = 1;
        end
      end
      prevHold = out_valid && !(out_ready && enable);
      prevData = out_data;
      if (out_valid && out_ready && enable) begin
        expW = 16'h1000 + 16'((int'(b) + words) % 256);
        checkOutput("word", 32'(out_data), 32'(expW));
        checkOutput("last", 32'(out_last), 32'(words == int'(c) - 1));
        if (words == 0) firstW = out_data;
        lastW = out_data;
        words++;
        hsCyc = cyc;
      end
      if (done) doneCyc = cyc;
      @(posedge clock);
      #1;
      cyc++;
    end
    start     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b0;
    checkOutput("done_seen", 32'(doneCyc >= 0), 1);
    checkOutput("word_count", 32'(words), 32'(c));
    checkOutput("idle_after_done", 32'(busy), 0);
    checkOutput("done_one_cycle", 32'(done), 0);
    if (emode == 0) begin
      if (c == 0) begin
        checkOutput("zero_done_cycle", 32'(doneCyc), 0);
        checkOutput("zero_busy_cycles", 32'(busyCyc), 1);
      end else begin
        checkOutput("first_valid_latency", 32'(firstValidCyc), 2);
        checkOutput("done_after_last_hs", 32'(doneCyc - hsCyc), 1);
      end
      checkOutput("mem_re_count", 32'(mreCnt), 32'(c));
    end else if (emode == 2) begin
      checkOutput("mem_re_reissue_count", 32'(mreCnt), 32'(int'(c) + 1));
    end else begin
      checkOutput("mem_re_min_count", 32'(mreCnt >= int'(c)), 1);
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] fw, lw;
    bit doneAny, busyAny;

    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    vecs[0] = '{8'h00, 9'd4,   0, 0, 16'h1000, 16'h1003};
    vecs[1] = '{8'hFE, 9'd3,   0, 0, 16'h10FE, 16'h1000};
    vecs[2] = '{8'h20, 9'd4,   2, 0, 16'h1020, 16'h1023};
    vecs[3] = '{8'h30, 9'd4,   0, 2, 16'h1030, 16'h1033};
    vecs[4] = '{8'hFF, 9'd1,   1, 0, 16'h10FF, 16'h10FF};
    vecs[5] = '{8'h80, 9'd0,   0, 0, 16'h0000, 16'h0000};
    vecs[6] = '{8'h05, 9'd256, 1, 0, 16'h1005, 16'h1004};
    vecs[7] = '{8'h7F, 9'd5,   1, 1, 16'h107F, 16'h1083};

    // Reset wins over a simultaneous start.
    reset     = 1'b1;
    enable    = 1'b1;
    start     = 1'b1;
    base_addr = 8'h33;
    count     = 9'd7;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkResetState("reset");
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      runDump(vecs[i].base, vecs[i].cnt, vecs[i].rmode, vecs[i].emode, fw, lw);
      if (vecs[i].cnt != 0) begin
        checkOutput($sformatf("vec%0d_first", i), 32'(fw), 32'(vecs[i].first));
        checkOutput($sformatf("vec%0d_last", i), 32'(lw), 32'(vecs[i].last));
      end
      repeat (2) @(posedge clock);
      #1;
    end

    $display("[TB] reset mid-dump");
    applyStimulus(8'h40, 9'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("pre_reset_valid", 32'(out_valid), 1);
    reset  = 1'b1;
    start  = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    checkResetState("midreset");
    reset   = 1'b0;
    start   = 1'b0;
    enable  = 1'b1;
    doneAny = 0;
    busyAny = 0;
    repeat (6) begin
      @(negedge clock);
      doneAny |= done;
      busyAny |= busy;
    end
    @(posedge clock);
    #1;
    checkOutput("aborted_no_done", 32'(doneAny), 0);
    checkOutput("aborted_stays_idle", 32'(busyAny), 0);
    runDump(8'h10, 9'd2, 0, 0, fw, lw);
    checkOutput("restart_first", 32'(fw), 32'h1010);
    checkOutput("restart_last", 32'(lw), 32'h1011);

    $display("[TB] randomized dumps");
    for (int i = 0; i < 20; i++) begin
      runDump(8'($urandom), 9'($urandom_range(0, 12)), 1, int'($urandom_range(0, 1)), fw, lw);
      @(posedge clock);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
